// File: rtl/dram_model.sv
// dram_model
//   Word-addressed external memory for the LeNet accelerator. It has one write
//   port and one read port, each with its own address. A read is sampled on the
//   edge that accepts it. Its data is presented RD_LATENCY cycles later, for
//   exactly one cycle, with valid=1. The read path is fully pipelined and keeps
//   request order. Memory contents survive reset.
//
//   Ports
//     clk       in   single clock, rising edge
//     srstn     in   asynchronous reset, active-high
//     en_wr     in   write enable
//     addr_wr   in   [ADDR_WIDTH-1:0] write word address
//     data_in   in   [DATA_WIDTH-1:0] write data
//     en_rd     in   read request
//     addr_rd   in   [ADDR_WIDTH-1:0] read word address
//     valid     out  data_out carries returned read data this cycle
//     data_out  out  [DATA_WIDTH-1:0] read data; holds last value when idle
//
//   Memory map used by the accelerator
//     Input image at 0. Ping-pong feature maps at 65536 and 131072.
//     Feature-map word = base + ch*H*W + row*W + col.
//   RD_LATENCY legal range: 1..8.

module dram_model #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned IMG_LAST = 65535;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [RD_LATENCY-1:0] vld_d, vld_q;
  logic [DATA_WIDTH-1:0] dat_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

  // Storage has no reset. A read in the same edge as a write to the same
  // address sees the old word, because the stage-0 capture and the write are
  // both non-blocking.
  always_ff @(posedge clk) begin
    if (en_wr) begin
      mem[addr_wr] <= data_in;
    end
  end

  // Each stage's data only advances when its upstream valid is set. The last
  // stage therefore holds the most recent result between pulses.
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = en_rd;
    if (en_rd) begin
      dat_d[0] = mem[addr_rd];
    end
    for (int unsigned k = 1; k < RD_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        dat_d[k] = dat_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < RD_LATENCY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign valid    = vld_q[RD_LATENCY-1];
  assign data_out = dat_q[RD_LATENCY-1];

`ifndef SYNTHESIS
  // Preload helpers. Each one overwrites only the words it addresses,
  // starting at the supplied base word address.
  task automatic load_words(input int unsigned base,
                            input logic [DATA_WIDTH-1:0] words [$]);
    for (int unsigned i = 0; i < words.size(); i++) begin
      mem[ADDR_WIDTH'(base + i)] = words[i];
    end
  endtask

  task automatic load_img(input logic [DATA_WIDTH-1:0] words [$]);
    for (int unsigned i = 0; i < words.size() && i <= IMG_LAST; i++) begin
      mem[ADDR_WIDTH'(i)] = words[i];
    end
  endtask

  task automatic load_l0_pre_data(input int unsigned base,
                                  input logic [DATA_WIDTH-1:0] words [$]);
    load_words(base, words);
  endtask

  task automatic load_l0_post_data(input int unsigned base,
                                   input logic [DATA_WIDTH-1:0] words [$]);
    load_words(base, words);
  endtask

  task automatic load_l1_data(input int unsigned base,
                              input logic [DATA_WIDTH-1:0] words [$]);
    load_words(base, words);
  endtask

  task automatic load_l2_pre_data(input int unsigned base,
                                  input logic [DATA_WIDTH-1:0] words [$]);
    load_words(base, words);
  endtask

  task automatic load_l2_post_data(input int unsigned base,
                                   input logic [DATA_WIDTH-1:0] words [$]);
    load_words(base, words);
  endtask

  task automatic load_l3_data(input int unsigned base,
                              input logic [DATA_WIDTH-1:0] words [$]);
    load_words(base, words);
  endtask

  task automatic print_result(input int unsigned base, input int unsigned w,
                              input int unsigned h, input int unsigned c);
    logic [ADDR_WIDTH-1:0] a;
    for (int unsigned ch = 0; ch < c; ch++) begin
      $display("channel %0d", ch);
      for (int unsigned row = 0; row < h; row++) begin
        for (int unsigned col = 0; col < w; col++) begin
          a = ADDR_WIDTH'(base + ch * h * w + row * w + col);
          $write("%0d ", $signed(mem[a]));
        end
        $display("");
      end
    end
  endtask
`endif

endmodule

// File: tb/tb_dram_model.sv
module tb_dram_model;

  logic        clk = 1'b0;
  logic        srstn;
  logic        en_wr;
  logic [17:0] addr_wr;
  logic [31:0] data_in;
  logic        en_rd;
  logic [17:0] addr_rd;
  logic        valid;
  logic [31:0] data_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  dram_model #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(18),
    .RD_LATENCY(2)
  ) dut (
    .clk      (clk),
    .srstn    (srstn),
    .en_wr    (en_wr),
    .addr_wr  (addr_wr),
    .data_in  (data_in),
    .en_rd    (en_rd),
    .addr_rd  (addr_rd),
    .valid    (valid),
    .data_out (data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [17:0] a, input logic [31:0] d);
    en_wr = 1'b1; addr_wr = a; data_in = d;
    tick();
    en_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] fm_addr;
    srstn = 1'b1; en_wr = 1'b0; en_rd = 1'b0;
    addr_wr = '0; addr_rd = '0; data_in = '0;

    // Reset state
    tick(); tick();
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_data", data_out, 32'd0);
    srstn = 1'b0;
    tick();

    // Write/readback with latency 2
    wr(18'd5, 32'hDEADBEEF);
    en_rd = 1'b1; addr_rd = 18'd5;
    tick();                           // request accepted
    en_rd = 1'b0;
    check("rb_lat1_valid", {31'b0, valid}, 32'd0);
    tick();
    check("rb_valid", {31'b0, valid}, 32'd1);
    check("rb_data", data_out, 32'hDEADBEEF);
    tick();
    check("rb_one_cycle", {31'b0, valid}, 32'd0);
    check("rb_hold", data_out, 32'hDEADBEEF);

    // Back-to-back reads of mem[i]=i
    for (int i = 0; i < 16; i++) wr(18'(100 + i), 32'(i));
    for (int j = 0; j <= 18; j++) begin
      if (j >= 2 && j <= 17) begin
        check("b2b_valid", {31'b0, valid}, 32'd1);
        check("b2b_data", data_out, 32'(j - 2));
      end else if (j != 0) begin
        check("b2b_idle", {31'b0, valid}, 32'd0);
      end
      en_rd = (j < 16); addr_rd = 18'(100 + j);
      tick();
    end
    check("b2b_hold", data_out, 32'd15);

    // Same-edge read/write collision returns the old word
    wr(18'd7, 32'd1);
    en_wr = 1'b1; addr_wr = 18'd7; data_in = 32'd2;
    en_rd = 1'b1; addr_rd = 18'd7;
    tick();
    en_wr = 1'b0;
    tick();
    en_rd = 1'b0;
    check("col_old_valid", {31'b0, valid}, 32'd1);
    check("col_old_data", data_out, 32'd1);
    tick();
    check("col_new_valid", {31'b0, valid}, 32'd1);
    check("col_new_data", data_out, 32'd2);
    tick();
    check("col_idle", {31'b0, valid}, 32'd0);

    // Address extremes, ping-pong bases and feature-map layout location
    fm_addr = 18'(65536 + 1 * 25 + 2 * 5 + 3);
    wr(18'h3FFFF, 32'hA5A5_5A5A);
    wr(18'h00000, 32'h1234_5678);
    wr(18'd65536, 32'h0000_0011);
    wr(18'd131072, 32'h0000_0022);
    wr(fm_addr, 32'hFFFF_FFF6);
    en_rd = 1'b1; addr_rd = 18'h3FFFF; tick();
    addr_rd = 18'h00000; tick();
    check("ext_hi", data_out, 32'hA5A5_5A5A);
    addr_rd = 18'd65536; tick();
    check("ext_lo", data_out, 32'h1234_5678);
    addr_rd = 18'd131072; tick();
    check("pp_a", data_out, 32'h0000_0011);
    addr_rd = 18'd65574; tick();
    check("pp_b", data_out, 32'h0000_0022);
    en_rd = 1'b0; tick();
    check("fm_loc_valid", {31'b0, valid}, 32'd1);
    check("fm_loc", data_out, 32'hFFFF_FFF6);
    tick();

    // Asynchronous reset with reads in flight
    en_rd = 1'b1; addr_rd = 18'd5; tick();
    addr_rd = 18'd7; tick();
    en_rd = 1'b0;
    check("pre_rst_valid", {31'b0, valid}, 32'd1);
    srstn = 1'b1;
    #1;
    check("arst_valid", {31'b0, valid}, 32'd0);
    check("arst_data", data_out, 32'd0);
    tick();
    srstn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_no_valid", {31'b0, valid}, 32'd0);
    end

    // Memory survives reset
    en_rd = 1'b1; addr_rd = 18'd5; tick();
    en_rd = 1'b0; tick();
    check("keep_valid", {31'b0, valid}, 32'd1);
    check("keep_data", data_out, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
